// File: rtl/ripple_counter.sv
// Free-running WIDTH-bit binary up-counter built as a synchronous toggle chain.
// Every bit is clocked by clk; reset is synchronous and active-high.
module ripple_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle_s;

    // Toggle enables: bit 0 always toggles, bit i toggles when all lower bits are 1.
    always_comb begin
        toggle_s    = {WIDTH{1'b0}};
        toggle_s[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            toggle_s[i] = toggle_s[i-1] & count_q[i-1];
        end
    end

    // Next-state: reset overrides the increment, otherwise flip the enabled bits.
    always_comb begin
        count_d = {WIDTH{1'b0}};
        if (rst) begin
            count_d = {WIDTH{1'b0}};
        end else begin
            count_d = count_q ^ toggle_s;
        end
    end

    // State register; rst only acts through count_d on the rising edge.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: tb/tb_ripple_counter.sv
// Directed, table-driven bench for ripple_counter at WIDTH=4 with a reference model
// and hand-written sequences for sub-cycle reset pulses.
module tb_ripple_counter;

    typedef struct packed {
        logic       rst;
        logic [3:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] count;
    logic [3:0] model;
    int         n_vec;
    int         n_miss;
    vec_t       vecs[$];

    ripple_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: count=%b expected=%b", name, $time, act, exp);
        end
    endtask

    // One edge: drive rst at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic [3:0] exp, input string name);
        @(negedge clk);
        rst = r;
        @(posedge clk);
        model = r ? 4'd0 : model + 4'd1;
        #1;
        check(name, count, exp);
        check("model", count, model);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        model  = 4'd0;
        rst    = 1'b1;

        // Count out of reset through wrap (1010 lands on the 105 ns edge).
        for (int i = 1; i < 16; i++) vecs.push_back('{1'b0, 4'(i)});
        vecs.push_back('{1'b0, 4'd0});
        // A further full 16-edge lap starting from 0.
        for (int i = 1; i < 16; i++) vecs.push_back('{1'b0, 4'(i)});
        vecs.push_back('{1'b0, 4'd0});
        // Held reset for five edges, then release.
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 4'd0});
        vecs.push_back('{1'b0, 4'd1});
        // One-edge reset at count=7.
        for (int i = 2; i < 8; i++) vecs.push_back('{1'b0, 4'(i)});
        vecs.push_back('{1'b1, 4'd0});
        vecs.push_back('{1'b0, 4'd1});
        // Reset at the all-ones value overrides the wrap increment.
        for (int i = 2; i < 16; i++) vecs.push_back('{1'b0, 4'(i)});
        vecs.push_back('{1'b1, 4'd0});
        vecs.push_back('{1'b0, 4'd1});

        @(posedge clk);
        #1;
        check("reset_first_edge", count, 4'd0);
        model = 4'd0;

        for (int v = 0; v < vecs.size(); v++) begin
            step(vecs[v].rst, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Narrow rst pulses between edges must not disturb the sequence.
        for (int k = 0; k < 4; k++) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
            @(posedge clk);
            model = model + 4'd1;
            #1;
            check("glitch_pulse", count, model);
        end
        check("glitch_end_value", count, 4'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
